leds_serializer: RTL and testbench



---
 rtl/leds_serializer_pkg.sv | 14 +
 rtl/leds_ser_tick.sv | 38 +++
 rtl/leds_serializer.sv | 157 +++++++++++++++
 tb/tb_leds_serializer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/leds_serializer_pkg.sv
// leds_serializer_pkg
// Shared definitions for the LED serializer: FSM state encoding.
package leds_serializer_pkg;

    // Serializer FSM states. The encoding is fixed so that debug probes on
    // the state register read the same values across builds.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } ser_state_e;

endpackage

// File: rtl/leds_ser_tick.sv
// leds_ser_tick
// Phase timer for the serializer. A down-counter is reloaded with CLK_DIV-1
// whenever the FSM changes state, and phase_end_o is high during the last
// system-clock cycle of the current phase (the CLK_DIV-th cycle in a state).
//
// Ports:
//   clk_i        system clock
//   rst_n_i      asynchronous active-low reset
//   restart_i    FSM changes state on this edge; start a new phase
//   phase_end_o  current phase has reached its final cycle
module leds_ser_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic restart_i,
    output logic phase_end_o
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] LOAD_VAL = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_r;

    // Down-counter: reload on phase start, otherwise count down and hold at zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_cnt_r <= {DW{1'b0}};
        end else if (restart_i) begin
            div_cnt_r <= LOAD_VAL;
        end else if (div_cnt_r != {DW{1'b0}}) begin
            div_cnt_r <= div_cnt_r - DW'(1'b1);
        end
    end

    assign phase_end_o = (div_cnt_r == {DW{1'b0}});

endmodule

// File: rtl/leds_serializer.sv
// leds_serializer
// Serializes a parallel LED word onto a 3-wire link (clock, data, latch) for a
// daisy-chained 74HC595-style driver. A frame is sent after every reset
// release and whenever leds_i differs from the last word sent; changes that
// arrive during a frame are coalesced into a single follow-up frame.
//
// Ports:
//   clk_i        system clock (rising edge)
//   rst_n_i      asynchronous active-low reset
//   leds_i       LED word, synchronous to clk_i
//   ser_clk_o    serial shift clock
//   ser_data_o   serial data, changes only with ser_clk_o falling
//   ser_latch_o  storage-register latch strobe (active-high)
//   busy_o       frame in progress
//   done_o       one-cycle pulse after the latch phase ends
module leds_serializer
    import leds_serializer_pkg::*;
#(
    parameter int NUM_LEDS  = 32,
    parameter int CLK_DIV   = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [NUM_LEDS-1:0] leds_i,
    output logic                ser_clk_o,
    output logic                ser_data_o,
    output logic                ser_latch_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int BW = $clog2(NUM_LEDS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NUM_LEDS - 1);

    ser_state_e          state_r;
    ser_state_e          state_next_s;
    logic [NUM_LEDS-1:0] shift_r;
    logic [NUM_LEDS-1:0] sent_r;
    logic [NUM_LEDS-1:0] shifted_s;
    logic [BW-1:0]       bit_cnt_r;
    logic                force_update_r;
    logic                load_s;
    logic                advance_s;
    logic                restart_s;
    logic                phase_end_s;
    logic                lead_in_s;
    logic                lead_shifted_s;
    logic                ser_clk_r;
    logic                ser_data_r;
    logic                ser_latch_r;
    logic                busy_r;
    logic                done_r;

    // Bit currently on the wire always sits at the leading end of shift_r;
    // advancing moves the next bit into that position.
    assign shifted_s      = MSB_FIRST ? (shift_r << 1'b1) : (shift_r >> 1'b1);
    assign lead_in_s      = MSB_FIRST ? leds_i[NUM_LEDS-1] : leds_i[0];
    assign lead_shifted_s = MSB_FIRST ? shifted_s[NUM_LEDS-1] : shifted_s[0];

    // Phase timing comes from the tick counter, restarted on every state change.
    assign restart_s = (state_next_s != state_r);

    leds_ser_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .restart_i   (restart_s),
        .phase_end_o (phase_end_s)
    );

    // Next-state logic plus frame-load and bit-advance strobes.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        advance_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (force_update_r || (leds_i != sent_r)) begin
                    state_next_s = SHIFT_LO;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT_LO: begin
                if (phase_end_s) begin
                    state_next_s = SHIFT_HI;
                end else begin
                    state_next_s = SHIFT_LO;
                end
            end
            SHIFT_HI: begin
                if (!phase_end_s) begin
                    state_next_s = SHIFT_HI;
                end else if (bit_cnt_r == LAST_BIT) begin
                    state_next_s = LATCH;
                end else begin
                    state_next_s = SHIFT_LO;
                    advance_s    = 1'b1;
                end
            end
            LATCH: begin
                if (phase_end_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = LATCH;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; outputs follow the next state
    // so they line up cycle-for-cycle with state_r.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r        <= IDLE;
            shift_r        <= {NUM_LEDS{1'b0}};
            sent_r         <= {NUM_LEDS{1'b0}};
            bit_cnt_r      <= {BW{1'b0}};
            force_update_r <= 1'b1;
            ser_clk_r      <= 1'b0;
            ser_data_r     <= 1'b0;
            ser_latch_r    <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            ser_clk_r   <= (state_next_s == SHIFT_HI);
            ser_latch_r <= (state_next_s == LATCH);
            busy_r      <= (state_next_s != IDLE);
            done_r      <= (state_r == LATCH) && (state_next_s == IDLE);
            if (load_s) begin
                shift_r        <= leds_i;
                sent_r         <= leds_i;
                force_update_r <= 1'b0;
                ser_data_r     <= lead_in_s;
                bit_cnt_r      <= {BW{1'b0}};
            end else if (advance_s) begin
                shift_r    <= shifted_s;
                ser_data_r <= lead_shifted_s;
                bit_cnt_r  <= bit_cnt_r + BW'(1'b1);
            end
        end
    end

    assign ser_clk_o   = ser_clk_r;
    assign ser_data_o  = ser_data_r;
    assign ser_latch_o = ser_latch_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;

endmodule

// File: tb/tb_leds_serializer.sv
// tb_leds_serializer
// Bench for leds_serializer. DUT A uses the default parameters and is driven
// with directed and random LED words; DUT B uses NUM_LEDS=8, CLK_DIV=1,
// MSB_FIRST=0. Monitors rebuild each frame from the serial pins and compare it
// with the LED word that was on leds_i when the frame started.
module tb_leds_serializer;

    localparam int N       = 32;
    localparam int DIV     = 4;
    localparam int FLEN    = 2 * DIV * N + DIV;
    localparam int N_B     = 8;
    localparam int DIV_B   = 1;
    localparam int FLEN_B  = 2 * DIV_B * N_B + DIV_B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n_a, rst_n_b;
    logic [N-1:0]  leds_a;
    logic [N_B-1:0] leds_b;
    logic sclk_a, data_a, latch_a, busy_a, done_a;
    logic sclk_b, data_b, latch_b, busy_b, done_b;

    leds_serializer #(.NUM_LEDS(N), .CLK_DIV(DIV), .MSB_FIRST(1'b1)) u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n_a), .leds_i(leds_a),
        .ser_clk_o(sclk_a), .ser_data_o(data_a), .ser_latch_o(latch_a),
        .busy_o(busy_a), .done_o(done_a)
    );

    leds_serializer #(.NUM_LEDS(N_B), .CLK_DIV(DIV_B), .MSB_FIRST(1'b0)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n_b), .leds_i(leds_b),
        .ser_clk_o(sclk_b), .ser_data_o(data_b), .ser_latch_o(latch_b),
        .busy_o(busy_b), .done_o(done_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- DUT A monitor ----------------
    bit           in_frame = 1'b0;
    bit           after_reset = 1'b1;
    int           busy_len = 0, latch_len = 0, nbits = 0;
    int           frames_a = 0, done_pulses = 0, idle_glitch = 0, data_glitch = 0;
    logic [N-1:0] rx_a = '0, frame_exp = '0, last_leds = '0, last_sent = '0, last_frame = '0;
    logic         prev_sclk = 1'b0, prev_data = 1'b0;

    // Sampled on the falling clock edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (!rst_n_a) begin
            in_frame    = 1'b0;
            after_reset = 1'b1;
            prev_sclk   = 1'b0;
            prev_data   = 1'b0;
            last_leds   = leds_a;
        end else begin
            bit start;
            start = busy_a && !in_frame;
            if (done_a) done_pulses++;
            if (start) begin
                in_frame  = 1'b1;
                frame_exp = last_leds;
                busy_len  = 0;
                latch_len = 0;
                nbits     = 0;
                rx_a      = '0;
                if (!after_reset)
                    check_val("frame_needs_change", 32'(frame_exp != last_sent), 32'd1);
                after_reset = 1'b0;
            end
            if (!start && (data_a != prev_data) && !(prev_sclk && !sclk_a))
                data_glitch++;
            if (busy_a) begin
                busy_len++;
                if (latch_a) latch_len++;
                if (sclk_a && !prev_sclk) begin
                    rx_a = {rx_a[N-2:0], data_a};
                    nbits++;
                end
            end else begin
                if (sclk_a || latch_a) idle_glitch++;
                if (in_frame) begin
                    in_frame = 1'b0;
                    check_val("busy_len", 32'(busy_len), 32'(FLEN));
                    check_val("bit_count", 32'(nbits), 32'(N));
                    check_val("latch_len", 32'(latch_len), 32'(DIV));
                    check_val("frame_data", rx_a, frame_exp);
                    check_val("done_at_end", 32'(done_a), 32'd1);
                    frames_a++;
                    last_sent  = frame_exp;
                    last_frame = rx_a;
                end
            end
            prev_sclk = sclk_a;
            prev_data = data_a;
            last_leds = leds_a;
        end
    end

    // ---------------- DUT B monitor ----------------
    bit             in_frame_b = 1'b0;
    int             busy_len_b = 0, nbits_b = 0, frames_b = 0;
    logic [N_B-1:0] rx_b = '0;
    logic           first_bit_b = 1'b0, prev_sclk_b = 1'b0;

    // Rebuilds LSB-first frames from DUT B's pins.
    always @(negedge clk) begin
        if (!rst_n_b) begin
            in_frame_b  = 1'b0;
            prev_sclk_b = 1'b0;
        end else begin
            if (busy_b) begin
                if (!in_frame_b) begin
                    in_frame_b = 1'b1;
                    busy_len_b = 0;
                    nbits_b    = 0;
                    rx_b       = '0;
                end
                busy_len_b++;
                if (sclk_b && !prev_sclk_b) begin
                    if (nbits_b == 0) first_bit_b = data_b;
                    if (nbits_b < N_B) rx_b[nbits_b] = data_b;
                    nbits_b++;
                end
            end else if (in_frame_b) begin
                in_frame_b = 1'b0;
                check_val("b_busy_len", 32'(busy_len_b), 32'(FLEN_B));
                check_val("b_bit_count", 32'(nbits_b), 32'(N_B));
                check_val("b_first_bit", 32'(first_bit_b), 32'd1);
                check_val("b_frame_data", 32'(rx_b), 32'h0000_0001);
                check_val("b_done", 32'(done_b), 32'd1);
                frames_b++;
            end
            prev_sclk_b = sclk_b;
        end
    end

    task automatic wait_frames(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (frames_a < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_val(tag, 32'(frames_a), 32'(target));
    endtask

    task automatic wait_busy(input string tag, input int budget);
        int n;
        n = 0;
        while (!busy_a && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check_val(tag, 32'(busy_a), 32'd1);
    endtask

    initial begin
        int base, base_done, n;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        leds_a  = '0;
        leds_b  = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outs_a", {27'd0, sclk_a, data_a, latch_a, busy_a, done_a}, 32'd0);
        check_val("reset_outs_b", {27'd0, sclk_b, data_b, latch_b, busy_b, done_b}, 32'd0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // Forced frame of zeros after reset, then 1000 quiet cycles.
        wait_frames("t1_first_frame", 1, 400);
        check_val("t1_frame_zero", last_frame, 32'd0);
        check_val("t1_done_count", 32'(done_pulses), 32'd1);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        check_val("t4_no_extra_frames", 32'(frames_a), 32'd1);
        check_val("t4_idle_quiet", 32'(idle_glitch), 32'd0);
        check_val("t4_busy_low", 32'(busy_a), 32'd0);
        check_val("b_one_frame", 32'(frames_b), 32'd1);

        // Corner bits.
        @(posedge clk); #1;
        leds_a = 32'h8000_0001;
        wait_frames("t2_frame", 2, 400);
        check_val("t2_data", last_frame, 32'h8000_0001);

        // Coalescing: two changes during one frame give one follow-up frame.
        base = frames_a;
        base_done = done_pulses;
        @(posedge clk); #1;
        leds_a = 32'h0000_00FF;
        wait_busy("t3_start", 20);
        repeat (30) @(posedge clk);
        #1 leds_a = 32'h0000_0F00;
        repeat (50) @(posedge clk);
        #1 leds_a = 32'h0000_F000;
        wait_frames("t3_two_frames", base + 2, 800);
        repeat (600) @(posedge clk);
        check_val("t3_no_third", 32'(frames_a), 32'(base + 2));
        check_val("t3_last", last_frame, 32'h0000_F000);
        check_val("t3_done_count", 32'(done_pulses - base_done), 32'd2);

        // Reset in the middle of a frame.
        base = frames_a;
        @(posedge clk); #1;
        leds_a = 32'hA5A5_A5A5;
        n = 0;
        while (!(in_frame && nbits >= 10) && n < 400) begin
            @(posedge clk);
            n++;
        end
        check_val("t5_reach_bit10", 32'(nbits >= 10), 32'd1);
        @(posedge clk);
        #2 rst_n_a = 1'b0;
        #1;
        check_val("t5_async_reset", {27'd0, sclk_a, data_a, latch_a, busy_a, done_a}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n_a = 1'b1;
        wait_frames("t5_resend", base + 1, 400);
        check_val("t5_data", last_frame, 32'hA5A5_A5A5);

        // Random LED words at random spacing, including repeats of the same word.
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) != 0) leds_a = $urandom;
            repeat ($urandom_range(0, 400)) @(posedge clk);
        end
        repeat (700) @(posedge clk);
        @(negedge clk);
        check_val("rand_settled_data", last_frame, leds_a);
        check_val("rand_settled_idle", 32'(busy_a), 32'd0);
        check_val("data_only_on_fall", 32'(data_glitch), 32'd0);
        check_val("idle_quiet_total", 32'(idle_glitch), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
